// File: rtl/morse_pkg.sv
// morse_pkg
//   Shared definitions for the Morse transmitter slice: FSM state encoding,
//   default timing constants and a small helper for sizing counters.
//   No ports.

package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_GAP  = 3'd2,
        ST_WGAP = 3'd3,
        ST_FIN  = 3'd4
    } morse_state_t;

    localparam int DEF_DASH_UNITS = 3;
    localparam int DEF_WORD_GAP   = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// morse_tick_gen
//   Produces a one-cycle tick every TICK_DIV Clock cycles. Built as a
//   down-counter with a terminal-count compare; clear reloads the counter
//   so that the first tick lands TICK_DIV cycles after clear drops.
// Ports
//   Clock   in   system clock
//   ResetN  in   asynchronous active-low reset
//   clear   in   synchronous reload, suppresses tick while high
//   tick    out  one-cycle pulse at terminal count

module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt <= '0;
        end else if (clear || (cnt == '0)) begin
            cnt <= CNT_W'(TICK_DIV - 1);
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/morse_tx.sv
// morse_tx
//   Transmits one Morse symbol (up to MAX_LEN dot/dash elements, bit0 first)
//   on led, optionally repeating it with a word gap between repetitions.
// Ports
//   Clock      in   system clock
//   ResetN     in   asynchronous active-low reset
//   start      in   begin transmission (accepted only in IDLE)
//   code_in    in   element pattern, 0=dot 1=dash
//   len_in     in   element count, clamped to MAX_LEN
//   repeat_en  in   loop the symbol while high
//   abort      in   synchronous cancel back to IDLE
//   led        out  registered mark output
//   busy       out  high outside IDLE
//   done       out  one-cycle pulse on normal completion
//
// state | meaning
// IDLE  | waiting for start, tick generator held in reload
// MARK  | led high for 1 (dot) or DASH_UNITS (dash) units
// GAP   | 1 unit inter-element space
// WGAP  | WORD_GAP units between repetitions
// FIN   | one cycle done pulse

module morse_tx
    import morse_pkg::*;
#(
    parameter int TICK_DIV   = 25000000,
    parameter int MAX_LEN    = 4,
    parameter int DASH_UNITS = DEF_DASH_UNITS,
    parameter int WORD_GAP   = DEF_WORD_GAP
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic                         start,
    input  logic [MAX_LEN-1:0]           code_in,
    input  logic [$clog2(MAX_LEN+1)-1:0] len_in,
    input  logic                         repeat_en,
    input  logic                         abort,
    output logic                         led,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int UNIT_W = $clog2(max_int(DASH_UNITS, WORD_GAP) + 1);

    morse_state_t state, next_state;

    logic [MAX_LEN-1:0] code_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_eff;
    logic [IDX_W-1:0]   idx;
    logic [UNIT_W-1:0]  unit_cnt;
    logic [UNIT_W-1:0]  mark_term;
    logic               last_elem;
    logic               tick;
    logic               tick_clear;

    logic latch, unit_clr, unit_inc, idx_clr, idx_inc;

    assign tick_clear = (state == ST_IDLE);

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clock  (Clock),
        .ResetN (ResetN),
        .clear  (tick_clear),
        .tick   (tick)
    );

    assign len_eff   = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
    // Terminal unit count of the current mark: a dot ends on its first tick.
    assign mark_term = code_q[idx] ? UNIT_W'(DASH_UNITS - 1) : '0;
    assign last_elem = (LEN_W'(idx) == (len_q - LEN_W'(1)));

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        latch      = 1'b0;
        unit_clr   = 1'b0;
        unit_inc   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    latch      = 1'b1;
                    unit_clr   = 1'b1;
                    idx_clr    = 1'b1;
                    next_state = (len_eff == '0) ? ST_FIN : ST_MARK;
                end
            end
            ST_MARK: begin
                if (tick) begin
                    if (unit_cnt == mark_term) begin
                        unit_clr   = 1'b1;
                        next_state = ST_GAP;
                    end else begin
                        unit_inc = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    unit_clr = 1'b1;
                    if (!last_elem) begin
                        idx_inc    = 1'b1;
                        next_state = ST_MARK;
                    end else if (repeat_en) begin
                        next_state = ST_WGAP;
                    end else begin
                        next_state = ST_FIN;
                    end
                end
            end
            ST_WGAP: begin
                if (tick) begin
                    if (unit_cnt == UNIT_W'(WORD_GAP - 1)) begin
                        unit_clr   = 1'b1;
                        idx_clr    = 1'b1;
                        next_state = ST_MARK;
                    end else begin
                        unit_inc = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // Cancel wins over start and every timing event.
        if (abort) begin
            next_state = ST_IDLE;
            latch      = 1'b0;
            unit_clr   = 1'b1;
            unit_inc   = 1'b0;
            idx_clr    = 1'b1;
            idx_inc    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            led      <= 1'b0;
            code_q   <= '0;
            len_q    <= '0;
            unit_cnt <= '0;
            idx      <= '0;
        end else begin
            led <= (next_state == ST_MARK);
            if (latch) begin
                code_q <= code_in;
                len_q  <= len_eff;
            end
            if (unit_clr) begin
                unit_cnt <= '0;
            end else if (unit_inc) begin
                unit_cnt <= unit_cnt + UNIT_W'(1);
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx
//   Self-checking bench for morse_tx with TICK_DIV=2, MAX_LEN=4.
//   Expected led run lengths and done pulses are queued when stimulus is
//   issued; a negedge monitor compresses the DUT outputs into the same
//   events and pops/compares them.

module tb_morse_tx;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       start = 1'b0;
    logic [3:0] code_in = '0;
    logic [2:0] len_in = '0;
    logic       repeat_en = 1'b0;
    logic       abort = 1'b0;
    logic       led, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // event encoding: kind*1000 + value; kind 0=high run, 1=low run, 2=done
    localparam int EV_HI = 0;
    localparam int EV_LO = 1;
    localparam int EV_DN = 2;
    int sb[$];

    morse_tx #(
        .TICK_DIV   (2),
        .MAX_LEN    (4),
        .DASH_UNITS (3),
        .WORD_GAP   (7)
    ) dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .start     (start),
        .code_in   (code_in),
        .len_in    (len_in),
        .repeat_en (repeat_en),
        .abort     (abort),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clock = ~Clock;

    function automatic void chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endfunction

    function automatic void sb_pop(input int got);
        if (sb.size() == 0) begin
            chk("sb_unexpected", got, -1);
        end else begin
            chk("sb_event", got, sb.pop_front());
        end
    endfunction

    task automatic push(input int kind, input int val);
        sb.push_back(kind * 1000 + val);
    endtask

    // Monitor: led runs are measured while busy and closed by done or idle.
    int   run = 0;
    logic prev_led = 1'b0;

    always @(negedge Clock) begin
        if (done) begin
            if (run > 0) sb_pop((prev_led ? EV_HI : EV_LO) * 1000 + run);
            sb_pop(EV_DN * 1000);
            run      = 0;
            prev_led = 1'b0;
        end else if (busy) begin
            if (run == 0 || led != prev_led) begin
                if (run > 0) sb_pop((prev_led ? EV_HI : EV_LO) * 1000 + run);
                prev_led = led;
                run      = 1;
            end else begin
                run++;
            end
        end else begin
            if (run > 0) sb_pop((prev_led ? EV_HI : EV_LO) * 1000 + run);
            run      = 0;
            prev_led = 1'b0;
        end
    end

    task automatic send(input logic [3:0] c, input logic [2:0] l);
        @(negedge Clock);
        code_in = c;
        len_in  = l;
        start   = 1'b1;
        @(negedge Clock);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit && busy; i++) @(negedge Clock);
        chk(tag, int'(busy), 0);
        repeat (2) @(negedge Clock);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        logic pl;

        repeat (3) @(negedge Clock);
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        ResetN = 1'b1;
        repeat (2) @(negedge Clock);

        // dot then dash
        push(EV_HI, 2); push(EV_LO, 2); push(EV_HI, 6); push(EV_LO, 2); push(EV_DN, 0);
        send(4'b0010, 3'd2);
        chk("basic_led_first", int'(led), 1);
        wait_idle("basic_idle", 100);

        // zero length: immediate done, no mark
        push(EV_DN, 0);
        send(4'b1111, 3'd0);
        chk("len0_done", int'(done), 1);
        chk("len0_led", int'(led), 0);
        @(negedge Clock);
        chk("len0_done_once", int'(done), 0);
        wait_idle("len0_idle", 10);

        // length clamped to 4: dot dash dot dash
        push(EV_HI, 2); push(EV_LO, 2); push(EV_HI, 6); push(EV_LO, 2);
        push(EV_HI, 2); push(EV_LO, 2); push(EV_HI, 6); push(EV_LO, 2); push(EV_DN, 0);
        send(4'b1010, 3'd7);
        wait_idle("clamp_idle", 200);

        // start while busy ignored
        push(EV_HI, 6); push(EV_LO, 2); push(EV_DN, 0);
        send(4'b0001, 3'd1);
        @(negedge Clock);
        code_in = 4'b0000;
        len_in  = 3'd3;
        start   = 1'b1;
        @(negedge Clock);
        start   = 1'b0;
        wait_idle("ignore_idle", 100);

        // repeat: three marks, drop repeat_en during the third
        push(EV_HI, 2); push(EV_LO, 16); push(EV_HI, 2); push(EV_LO, 16);
        push(EV_HI, 2); push(EV_LO, 2); push(EV_DN, 0);
        repeat_en = 1'b1;
        send(4'b0000, 3'd1);
        rises = 0;
        pl    = 1'b0;
        for (int i = 0; i < 400 && rises < 3; i++) begin
            @(negedge Clock);
            if (led && !pl) rises++;
            pl = led;
        end
        chk("rep_rises", rises, 3);
        repeat_en = 1'b0;
        wait_idle("rep_idle", 100);

        // abort during a dash
        push(EV_HI, 3);
        send(4'b0001, 3'd1);
        repeat (2) @(negedge Clock);
        abort = 1'b1;
        @(negedge Clock);
        abort = 1'b0;
        chk("abort_led", int'(led), 0);
        chk("abort_busy", int'(busy), 0);
        wait_idle("abort_idle", 10);
        push(EV_HI, 2); push(EV_LO, 2); push(EV_HI, 6); push(EV_LO, 2); push(EV_DN, 0);
        send(4'b0010, 3'd2);
        wait_idle("post_abort_idle", 100);

        // asynchronous reset mid-mark
        push(EV_HI, 2);
        send(4'b0001, 3'd1);
        @(negedge Clock);
        #3 ResetN = 1'b0;
        #1;
        chk("arst_led", int'(led), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge Clock);
        #2 ResetN = 1'b1;
        repeat (4) @(negedge Clock);
        chk("arst_idle_busy", int'(busy), 0);
        chk("arst_sb_empty", sb.size(), 0);
        push(EV_HI, 2); push(EV_LO, 2); push(EV_DN, 0);
        send(4'b0000, 3'd1);
        wait_idle("post_rst_idle", 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
